// File: rtl/mips32_pkg.sv
// Shared definitions for the mips32 program loader: loader states and frame constants.
package mips32_pkg;

   typedef enum logic [2:0] {
      ST_HDR0,
      ST_HDR1,
      ST_DATA,
      ST_CHK,
      ST_RUN,
      ST_ERR
   } ld_state_e;

   localparam logic [5:0] HLT_OPCODE = 6'h3f;
   localparam int         HDR_W      = 16;

endpackage

// File: rtl/mips32_word_assembler.sv
// Shifts stream bytes into a big-endian 32-bit word and keeps the running XOR checksum.
module mips32_word_assembler (
   input  logic        clk1,
   input  logic        rst_n,
   input  logic        clr_i,
   input  logic        xor_en_i,
   input  logic        shift_en_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_done_o,
   output logic [7:0]  csum_o
);

   logic [23:0] word_q;
   logic [1:0]  idx_q;
   logic [7:0]  csum_q;

   // word_o is the word as it will stand once byte_i is shifted in, so the
   // top can capture a complete word on the same edge as the 4th byte.
   assign word_o      = {word_q, byte_i};
   assign word_done_o = shift_en_i && (idx_q == 2'd3);
   assign csum_o      = csum_q;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= '0;
         idx_q  <= '0;
         csum_q <= '0;
      end else if (clr_i) begin
         word_q <= '0;
         idx_q  <= '0;
         csum_q <= '0;
      end else begin
         if (xor_en_i) begin
            csum_q <= csum_q ^ byte_i;
         end
         if (shift_en_i) begin
            word_q <= word_o[23:0];
            idx_q  <= idx_q + 2'd1;
         end
      end
   end

endmodule

// File: rtl/mips32_prog_loader.sv
// Byte-serial frame loader: writes the program into instruction memory while
// holding the core, checks the XOR trailer, then releases the core.
module mips32_prog_loader
   import mips32_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0,
   parameter int MAX_WORDS = 1024
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              restart,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              cpu_start,
   output logic              load_err,
   output logic [ADDR_W:0]   words_loaded
);

   ld_state_e         state_q, state_d;
   logic [7:0]        count_hi_q, count_hi_d;
   logic [HDR_W-1:0]  count_q, count_d;
   logic [ADDR_W:0]   words_q, words_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              start_q, start_d;

   logic              accept;
   logic              rearm;
   logic [HDR_W-1:0]  hdr_n;
   logic [31:0]       asm_word;
   logic              asm_done;
   logic [7:0]        asm_csum;

   assign in_ready = (state_q == ST_HDR0) || (state_q == ST_HDR1) ||
                     (state_q == ST_DATA) || (state_q == ST_CHK);
   assign accept   = in_valid && in_ready;
   assign rearm    = restart && ((state_q == ST_RUN) || (state_q == ST_ERR));
   assign hdr_n    = {count_hi_q, in_data};

   mips32_word_assembler u_asm (
      .clk1        (clk1),
      .rst_n       (rst_n),
      .clr_i       (rearm),
      .xor_en_i    (accept && (state_q != ST_CHK)),
      .shift_en_i  (accept && (state_q == ST_DATA)),
      .byte_i      (in_data),
      .word_o      (asm_word),
      .word_done_o (asm_done),
      .csum_o      (asm_csum)
   );

   // NOTE: every variable is defaulted before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d     = state_q;
      count_hi_d  = count_hi_q;
      count_d     = count_q;
      words_d     = words_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      unique case (state_q)
         ST_HDR0: begin
            if (accept) begin
               count_hi_d = in_data;
               state_d    = ST_HDR1;
            end
         end
         ST_HDR1: begin
            if (accept) begin
               count_d = hdr_n;
               if (int'(hdr_n) > MAX_WORDS) begin
                  state_d = ST_ERR;
               end else if (hdr_n == '0) begin
                  state_d = ST_CHK;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (asm_done) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = ADDR_W'(BASE_ADDR) + words_q[ADDR_W-1:0];
               mem_wdata_d = asm_word;
               words_d     = words_q + (ADDR_W+1)'(1);
               if (int'(words_q) + 1 == int'(count_q)) begin
                  state_d = ST_CHK;
               end
            end
         end
         ST_CHK: begin
            if (accept) begin
               state_d = (in_data == asm_csum) ? ST_RUN : ST_ERR;
            end
         end
         ST_RUN, ST_ERR: begin
            if (restart) begin
               state_d = ST_HDR0;
               words_d = '0;
            end
         end
         default: state_d = ST_HDR0;
      endcase

      // Registered so the pulse lines up with the first cycle spent in RUN.
      start_d = (state_d == ST_RUN) && (state_q != ST_RUN);
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_HDR0;
         count_hi_q  <= '0;
         count_q     <= '0;
         words_q     <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= ADDR_W'(BASE_ADDR);
         mem_wdata_q <= '0;
         start_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_hi_q  <= count_hi_d;
         count_q     <= count_d;
         words_q     <= words_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         start_q     <= start_d;
      end
   end

   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign cpu_start    = start_q;
   assign cpu_hold     = (state_q != ST_RUN);
   assign load_err     = (state_q == ST_ERR);
   assign words_loaded = words_q;

endmodule
